eth_pcs_rx_block_synch_mlane: RTL and testbench

Multi-lane, parameterised 64b/66b block-lock engine for the Ethernet PCS receive path. It sits between the per-lane RX gearboxes and the descramblers. Each lane runs an independent lock state machine on its 2-bit sync headers and issues bit-slip requests back to its gearbox. Compared with the single-lane synchroniser, it adds configurable thresholds, a post-slip settle window, per-lane enable and an aggregate lock output.

---
 rtl/eth_pcs_rx_block_synch_mlane.sv | 107 ++++++++++
 tb/tb_eth_pcs_rx_block_synch_mlane.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_rx_block_synch_mlane.sv
// eth_pcs_rx_block_synch_mlane: per-lane 64b/66b sync-header block lock with
// gearbox slip requests, post-slip settle window and aggregate lock.
module eth_pcs_rx_block_synch_mlane #(
  parameter int N_LANES     = 4,
  parameter int W_SYNC      = 2,
  parameter int SH_TH       = 64,
  parameter int SH_INVAL_TH = 16,
  parameter int SLIP_WAIT   = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_LANES-1:0]        i_lane_en,
  input  logic [N_LANES-1:0]        i_valid,
  input  logic [N_LANES*W_SYNC-1:0] i_sync_hdr,
  output logic [N_LANES-1:0]        o_rx_lock,
  output logic [N_LANES-1:0]        o_slip,
  output logic                      o_all_lock
);
  localparam int SW = $clog2(SH_TH + 1);
  localparam int IW = $clog2(SH_INVAL_TH + 1);
  localparam int WW = SLIP_WAIT > 0 ? $clog2(SLIP_WAIT + 1) : 1;
  typedef enum logic [1:0] {UNLOCKED, LOCKED, WAIT} state_t;
  logic all_q;
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    state_t          st_q, st_d;
    logic [SW-1:0]   sh_q, sh_d;
    logic [IW-1:0]   iv_q, iv_d;
    logic [WW-1:0]   wt_q, wt_d;
    logic            lock_q, lock_d, slip_q, slip_d;
    logic            hv, slip;
    logic [W_SYNC-1:0] hdr;
    assign hdr = i_sync_hdr[l*W_SYNC +: W_SYNC];
    assign hv  = (hdr == W_SYNC'(1)) || (hdr == W_SYNC'(2));
    always_ff @(posedge i_clk)
      if (i_reset) begin
        st_q   <= UNLOCKED;
        sh_q   <= '0;
        iv_q   <= '0;
        wt_q   <= '0;
        lock_q <= 1'b0;
        slip_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        sh_q   <= sh_d;
        iv_q   <= iv_d;
        wt_q   <= wt_d;
        lock_q <= lock_d;
        slip_q <= slip_d;
      end
    always_comb begin
      st_d = st_q;
      sh_d = sh_q;
      iv_d = iv_q;
      wt_d = wt_q;
      slip = 1'b0;
      if (!i_lane_en[l]) begin
        st_d = UNLOCKED;
        sh_d = '0;
        iv_d = '0;
        wt_d = '0;
      end else if (i_valid[l]) begin
        case (st_q)
          UNLOCKED: begin
            slip = !hv;
            sh_d = sh_q + SW'(1);
            if (hv && sh_q == SW'(SH_TH - 1)) begin
              st_d = LOCKED;
              sh_d = '0;
            end
          end
          LOCKED: begin
            sh_d = sh_q + SW'(1);
            iv_d = iv_q + IW'(!hv);
            // Lock loss outranks the window-end clear on the same beat
            if (!hv && iv_q == IW'(SH_INVAL_TH - 1))
              slip = 1'b1;
            else if (sh_q == SW'(SH_TH - 1)) begin
              sh_d = '0;
              iv_d = '0;
            end
          end
          WAIT: begin
            wt_d = wt_q - WW'(1);
            st_d = wt_q == WW'(1) ? UNLOCKED : WAIT;
          end
          default: st_d = UNLOCKED;
        endcase
        if (slip) begin
          sh_d = '0;
          iv_d = '0;
          wt_d = WW'(SLIP_WAIT);
          st_d = SLIP_WAIT == 0 ? UNLOCKED : WAIT;
        end
      end
    end
    always_comb begin
      lock_d = st_d == LOCKED;
      slip_d = slip;
    end
    assign o_rx_lock[l] = lock_q;
    assign o_slip[l]    = slip_q;
  end
  always_ff @(posedge i_clk)
    if (i_reset) all_q <= 1'b0;
    else all_q <= (|i_lane_en) && (&(o_rx_lock | ~i_lane_en));
  assign o_all_lock = all_q;
endmodule

// File: tb/tb_eth_pcs_rx_block_synch_mlane.sv
// tb_eth_pcs_rx_block_synch_mlane: randomized and directed stimulus against a
// behavioural lock model, checked through an expected-output queue.
module tb_eth_pcs_rx_block_synch_mlane;
  localparam int NL = 4, WS = 2, SHT = 64, SIT = 16, SWT = 2;
  typedef struct packed {
    logic [NL-1:0] lock;
    logic [NL-1:0] slip;
    logic          all;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [NL-1:0] en = '0, vld = '0;
  logic [NL*WS-1:0] hdr = '0;
  logic [NL-1:0] lock, slip;
  logic all;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [NL-1:0] m_lk = '0;
  int m_wt[NL], m_cnt[NL], m_bad[NL];
  int vps[3] = '{100, 70, 30};
  int bps[5] = '{0, 0, 1, 5, 30};

  always #5 clk = ~clk;

  eth_pcs_rx_block_synch_mlane #(
    .N_LANES(NL), .W_SYNC(WS), .SH_TH(SHT), .SH_INVAL_TH(SIT), .SLIP_WAIT(SWT)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_lane_en(en), .i_valid(vld), .i_sync_hdr(hdr),
    .o_rx_lock(lock), .o_slip(slip), .o_all_lock(all)
  );

  task automatic clear_lane(input int l);
    m_lk[l] = 1'b0;
    m_wt[l] = 0;
    m_cnt[l] = 0;
    m_bad[l] = 0;
  endtask

  // One beat: drive inputs, let the edge happen, then predict the outputs it produces
  task automatic beat(input logic r, input logic [NL-1:0] e, input logic [NL-1:0] v,
                      input logic [NL-1:0] b);
    exp_t x;
    logic [NL-1:0] pl;
    rst = r;
    en = e;
    vld = v;
    for (int l = 0; l < NL; l++)
      hdr[l*WS +: WS] = b[l] ? (($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11)
                             : (($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10);
    @(posedge clk);
    x = '0;
    pl = m_lk;
    if (r) begin
      for (int l = 0; l < NL; l++) clear_lane(l);
    end else begin
      x.all = (e != '0) && ((pl | ~e) == '1);
      for (int l = 0; l < NL; l++) begin
        if (!e[l]) clear_lane(l);
        else if (v[l]) begin
          if (m_wt[l] > 0) m_wt[l]--;
          else if (!m_lk[l]) begin
            if (b[l]) x.slip[l] = 1'b1;
            else if (++m_cnt[l] == SHT) begin
              m_lk[l] = 1'b1;
              m_cnt[l] = 0;
            end
          end else begin
            m_cnt[l]++;
            if (b[l]) m_bad[l]++;
            if (b[l] && m_bad[l] == SIT) begin
              x.slip[l] = 1'b1;
              m_lk[l] = 1'b0;
            end else if (m_cnt[l] == SHT) begin
              m_cnt[l] = 0;
              m_bad[l] = 0;
            end
          end
          if (x.slip[l]) begin
            m_cnt[l] = 0;
            m_bad[l] = 0;
            m_wt[l] = SWT;
          end
        end
        x.lock[l] = m_lk[l];
      end
    end
    q.push_back(x);
    #1;
  endtask

  task automatic rnd(input int n, input logic [NL-1:0] e, input int vp, input int bp);
    logic [NL-1:0] v, b;
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < NL; l++) begin
        v[l] = $urandom_range(0, 99) < vp;
        b[l] = $urandom_range(0, 99) < bp;
      end
      beat(1'b0, e, v, b);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if ({lock, slip, all} !== x) begin
          errors++;
          $display("FAIL outputs t=%0t lock=%b slip=%b all=%b expected lock=%b slip=%b all=%b",
                   $time, lock, slip, all, x.lock, x.slip, x.all);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [NL-1:0] b;
    for (int l = 0; l < NL; l++) clear_lane(l);
    repeat (2) beat(1'b1, '0, '0, '0);
    // Acquisition on lane 0 alone
    repeat (SHT) beat(1'b0, 4'b0001, 4'b0001, '0);
    repeat (3) beat(1'b0, 4'b0001, 4'b0001, '0);
    // Lock loss: 16 invalid within one window, then settle window and re-slip
    repeat (SIT) begin
      beat(1'b0, 4'b0001, 4'b0001, 4'b0001);
      beat(1'b0, 4'b0001, 4'b0001, 4'b0000);
    end
    repeat (4) beat(1'b0, 4'b0001, 4'b0001, 4'b0001);
    // Unlocked slip at beat 10 after reset
    beat(1'b1, 4'b0001, 4'b0001, '0);
    repeat (9) beat(1'b0, 4'b0001, 4'b0001, '0);
    repeat (4) beat(1'b0, 4'b0001, 4'b0001, 4'b0001);
    // Reacquire, then two windows with 15 invalid each
    repeat (SHT + 2) beat(1'b0, 4'b0001, 4'b0001, '0);
    beat(1'b1, 4'b0001, 4'b0001, '0);
    repeat (SHT) beat(1'b0, 4'b0001, 4'b0001, '0);
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < SHT; i++)
        beat(1'b0, 4'b0001, 4'b0001, (i % 4 == 0 && i < 60) ? 4'b0001 : 4'b0000);
    // Valid gap mid-acquisition
    beat(1'b1, 4'b0001, 4'b0001, '0);
    repeat (30) beat(1'b0, 4'b0001, 4'b0001, '0);
    repeat (100) beat(1'b0, 4'b0001, 4'b0000, 4'($urandom));
    repeat (36) beat(1'b0, 4'b0001, 4'b0001, '0);
    // Staggered multi-lane acquisition
    for (int i = 0; i < 130; i++) begin
      for (int l = 0; l < NL; l++) b[l] = i < l * 15;
      beat(1'b0, '1, '1, b);
    end
    repeat (SIT + 3) beat(1'b0, '1, '1, 4'b1000);
    repeat (10) beat(1'b0, 4'b0111, '1, '0);
    repeat (5) beat(1'b0, '1, '1, '0);
    repeat (3) beat(1'b0, '0, '1, '0);
    // Reset during the settle window
    beat(1'b0, '1, '1, 4'b0101);
    beat(1'b1, '1, '1, '0);
    repeat (3) beat(1'b0, '1, '1, '0);
    for (int s = 0; s < 40; s++)
      rnd(100, ($urandom_range(0, 3) == 0) ? NL'($urandom) : '1,
          vps[$urandom_range(0, 2)], bps[$urandom_range(0, 4)]);
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
